por_reset_sequencer: RTL

- Consumer end of the power-on reset path. Takes the 1.8 V-domain POR (active-low) as its asynchronous reset and the external reset pin as a second reset source.
- Filters the pin, then releases three staged domain resets in order: housekeeping, then core, then user project. Each release is separated by a programmable cycle delay.
- Also serves a 4-phase soft-reset handshake from housekeeping and records the cause of the last reset.

---
 rtl/por_seq_pkg.sv | 7 +
 rtl/reset_pin_filter.sv | 31 +++
 rtl/por_reset_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/por_seq_pkg.sv
// por_seq_pkg: shared state encoding and reset-cause codes for the POR reset sequencer
package por_seq_pkg;
    typedef enum logic [2:0] {HOLD, WAIT_CORE, WAIT_USER, RUN, SOFT} state_t;
    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_PIN  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;
endpackage

// File: rtl/reset_pin_filter.sv
// reset_pin_filter: synchronizes the external reset pin and debounces it
module reset_pin_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 8
) (
    input  logic clk,
    input  logic resetb,
    input  logic pin_in,
    output logic pin_filt
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          dcnt;
    // shift the asynchronous pin into the clk domain; resets to "pin asserted"
    always_ff @(posedge clk or negedge resetb)
        if (!resetb) sync <= '0;
        else         sync <= {sync[SYNC_STAGES-2:0], pin_in};
    // accept a new level only after it persists for DEBOUNCE consecutive edges
    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            dcnt     <= '0;
            pin_filt <= 1'b0;
        end else if (sync[SYNC_STAGES-1] == pin_filt) begin
            dcnt <= '0;
        end else if (dcnt == DW'(DEBOUNCE - 1)) begin
            dcnt     <= '0;
            pin_filt <= ~pin_filt;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
endmodule

// File: rtl/por_reset_sequencer.sv
// por_reset_sequencer: staged hk/core/user reset release with pin filter, soft-reset handshake and cause tracking
module por_reset_sequencer
    import por_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 8,
    parameter int STAGE_DLY   = 16
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       ext_resetb_pin,
    input  logic       soft_rst_req,
    output logic       soft_rst_ack,
    output logic       rstb_hk,
    output logic       rstb_core,
    output logic       rstb_user,
    output logic       seq_done,
    output logic [1:0] reset_cause
);
    localparam int CW = $clog2(STAGE_DLY + 1);
    state_t        state;
    logic [CW-1:0] cnt;
    logic          pin_filt;
    logic          last;

    reset_pin_filter #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_filt (
        .clk      (clk),
        .resetb   (resetb),
        .pin_in   (ext_resetb_pin),
        .pin_filt (pin_filt)
    );

    assign last = cnt == CW'(STAGE_DLY - 1);

    // sequencer: pin assertion outranks everything, then stage releases and the soft handshake
    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            state        <= HOLD;
            cnt          <= '0;
            rstb_hk      <= 1'b0;
            rstb_core    <= 1'b0;
            rstb_user    <= 1'b0;
            seq_done     <= 1'b0;
            soft_rst_ack <= 1'b0;
            reset_cause  <= CAUSE_POR;
        end else if (state != HOLD && !pin_filt) begin
            state        <= HOLD;
            cnt          <= '0;
            rstb_hk      <= 1'b0;
            rstb_core    <= 1'b0;
            rstb_user    <= 1'b0;
            seq_done     <= 1'b0;
            soft_rst_ack <= 1'b0;
            reset_cause  <= CAUSE_PIN;
        end else begin
            case (state)
                HOLD:
                    if (!pin_filt) cnt <= '0;
                    else if (last) begin
                        rstb_hk <= 1'b1;
                        cnt     <= '0;
                        state   <= WAIT_CORE;
                    end else cnt <= cnt + 1'b1;
                WAIT_CORE:
                    if (last) begin
                        rstb_core <= 1'b1;
                        cnt       <= '0;
                        state     <= WAIT_USER;
                    end else cnt <= cnt + 1'b1;
                WAIT_USER:
                    if (last) begin
                        rstb_user <= 1'b1;
                        seq_done  <= 1'b1;
                        cnt       <= '0;
                        state     <= RUN;
                    end else cnt <= cnt + 1'b1;
                RUN:
                    if (soft_rst_req) begin
                        rstb_core    <= 1'b0;
                        rstb_user    <= 1'b0;
                        seq_done     <= 1'b0;
                        soft_rst_ack <= 1'b1;
                        reset_cause  <= CAUSE_SOFT;
                        state        <= SOFT;
                    end
                SOFT:
                    if (!soft_rst_req) begin
                        soft_rst_ack <= 1'b0;
                        cnt          <= '0;
                        state        <= WAIT_CORE;
                    end
                default: state <= HOLD;
            endcase
        end
endmodule
